regfile_wb: RTL and testbench

- Architectural register file for the THCO-MIPS core, and the consuming end of the MEM/WB write-back bundle (write data, write enable, write address).
- Holds R0–R7 plus the special registers SP, IH, RA and T.
- Provides two read ports to the ID stage and one debug read port.
- Applies exactly one write-back per clock edge, with an optional same-cycle write-to-read bypass.

---
 rtl/regfile_wb_if.sv | 31 +++
 rtl/regfile_wb.sv | 72 +++++++
 tb/tb_regfile_wb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// MEM/WB write-back bundle plus the ID-stage and debug read ports of the THCO-MIPS register file.
// master: the pipeline side (MEM/WB and ID). slave: the register file.
interface regfile_wb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              wReg_i;
   logic [ADDR_W-1:0] wRegAddr_i;
   logic [DATA_W-1:0] wData_i;
   logic              re1_i;
   logic [ADDR_W-1:0] rAddr1_i;
   logic [DATA_W-1:0] rData1_o;
   logic              re2_i;
   logic [ADDR_W-1:0] rAddr2_i;
   logic [DATA_W-1:0] rData2_o;
   logic [ADDR_W-1:0] dbgAddr_i;
   logic [DATA_W-1:0] dbgData_o;
   logic [DATA_W-1:0] wrCount_o;

   modport master (
      output wReg_i, wRegAddr_i, wData_i,
      output re1_i, rAddr1_i, re2_i, rAddr2_i, dbgAddr_i,
      input  rData1_o, rData2_o, dbgData_o, wrCount_o
   );

   modport slave (
      input  wReg_i, wRegAddr_i, wData_i,
      input  re1_i, rAddr1_i, re2_i, rAddr2_i, dbgAddr_i,
      output rData1_o, rData2_o, dbgData_o, wrCount_o
   );
endinterface

// File: rtl/regfile_wb.sv
// THCO-MIPS register file (R0-R7, SP, IH, RA, T): one write-back per edge, two ID read ports, one debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the ID read ports.
module regfile_wb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 12
) (
   input  logic         clk,
   input  logic         rst,
   regfile_wb_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LP_NUM_REGS = ADDR_W'(NUM_REGS);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [DATA_W-1:0] r_wr_count;

   logic              w_wr_en;
   logic              w_byp1;
   logic              w_byp2;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;
   logic [DATA_W-1:0] w_dbg_data;

   assign w_wr_en = bus.wReg_i && (bus.wRegAddr_i < LP_NUM_REGS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_wr_count <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.wRegAddr_i] <= bus.wData_i;
         r_wr_count             <= r_wr_count + DATA_W'(1);
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Gated by rst so that reads show zero while reset is held, even with a write pending.
   assign w_byp1 = rst && w_wr_en && (bus.rAddr1_i == bus.wRegAddr_i);
   assign w_byp2 = rst && w_wr_en && (bus.rAddr2_i == bus.wRegAddr_i);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   always_comb begin
      w_rdata1 = '0;
      if (bus.re1_i && (bus.rAddr1_i < LP_NUM_REGS)) begin
         if (w_byp1) w_rdata1 = bus.wData_i;
         else        w_rdata1 = r_regs[bus.rAddr1_i];
      end
   end

   always_comb begin
      w_rdata2 = '0;
      if (bus.re2_i && (bus.rAddr2_i < LP_NUM_REGS)) begin
         if (w_byp2) w_rdata2 = bus.wData_i;
         else        w_rdata2 = r_regs[bus.rAddr2_i];
      end
   end

   always_comb begin
      w_dbg_data = '0;
      if (bus.dbgAddr_i < LP_NUM_REGS) w_dbg_data = r_regs[bus.dbgAddr_i];
   end

   assign bus.rData1_o  = w_rdata1;
   assign bus.rData2_o  = w_rdata2;
   assign bus.dbgData_o = w_dbg_data;
   assign bus.wrCount_o = r_wr_count;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: scoreboard of expected values checked against the DUT outputs.
// Expectations for the same-cycle hazard follow REGFILE_BYPASS_EN.
module tb_regfile_wb;

   logic clk;
   logic rst;

   regfile_wb_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   regfile_wb #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q [$];
   string       tag_q [$];

   logic [15:0] m_regs [12];
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [15:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic sb_check(input logic [15:0] obs);
      string       t;
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow got=%h expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk(t, obs, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 12; i++) m_regs[i] = 16'h0000;
      m_cnt = 16'h0000;
   endtask

   // Drive one write for one edge; returns at posedge+1 with the write removed.
   task automatic wr(input logic [3:0] addr, input logic [15:0] data);
      bus.wReg_i     = 1'b1;
      bus.wRegAddr_i = addr;
      bus.wData_i    = data;
      @(posedge clk);
      #1;
      bus.wReg_i = 1'b0;
      if (addr < 4'd12) begin
         m_regs[addr] = data;
         m_cnt        = m_cnt + 16'd1;
      end
   endtask

   task automatic check_all_dbg(input string tag);
      for (int i = 0; i < 12; i++) begin
         bus.dbgAddr_i = 4'(i);
         sb_push(tag, m_regs[i]);
         #1;
         sb_check(bus.dbgData_o);
      end
   endtask

   initial begin
      rst            = 1'b0;
      bus.wReg_i     = 1'b0;
      bus.wRegAddr_i = 4'hF;
      bus.wData_i    = 16'h0000;
      bus.re1_i      = 1'b1;
      bus.rAddr1_i   = 4'd0;
      bus.re2_i      = 1'b1;
      bus.rAddr2_i   = 4'd0;
      bus.dbgAddr_i  = 4'd0;
      model_reset();

      // reset state
      #2;
      sb_push("rst_r1", 16'h0000);  sb_push("rst_r2", 16'h0000);
      sb_push("rst_dbg", 16'h0000); sb_push("rst_cnt", 16'h0000);
      #1;
      sb_check(bus.rData1_o); sb_check(bus.rData2_o);
      sb_check(bus.dbgData_o); sb_check(bus.wrCount_o);
      #9 rst = 1'b1;
      @(posedge clk); #1;

      // async reset mid-cycle, write held through reset lands after release
      wr(4'd3, 16'h1234);
      bus.rAddr1_i = 4'd3;
      sb_push("pre_rst_r3", m_regs[3]);
      #1 sb_check(bus.rData1_o);
      bus.wReg_i = 1'b1; bus.wRegAddr_i = 4'd4; bus.wData_i = 16'h4444;
      bus.rAddr2_i = 4'd4;
      #1 rst = 1'b0;
      model_reset();
      sb_push("async_r3", 16'h0000); sb_push("async_r2", 16'h0000); sb_push("async_cnt", 16'h0000);
      #1;
      sb_check(bus.rData1_o); sb_check(bus.rData2_o); sb_check(bus.wrCount_o);
      @(posedge clk); #1;
      bus.dbgAddr_i = 4'd4;
      sb_push("rst_blocks_wr", 16'h0000);
      #1 sb_check(bus.dbgData_o);
      rst = 1'b1;
      @(posedge clk); #1;
      bus.wReg_i = 1'b0;
      m_regs[4] = 16'h4444; m_cnt = m_cnt + 16'd1;
      sb_push("first_wr_r4", m_regs[4]); sb_push("first_wr_cnt", m_cnt);
      #1;
      sb_check(bus.dbgData_o); sb_check(bus.wrCount_o);

      // basic write/read of SP
      wr(4'd8, 16'hBEEF);
      bus.rAddr1_i = 4'd8; bus.rAddr2_i = 4'd8; bus.dbgAddr_i = 4'd8;
      sb_push("sp_r1", m_regs[8]); sb_push("sp_r2", m_regs[8]);
      sb_push("sp_dbg", m_regs[8]); sb_push("sp_cnt", m_cnt);
      #1;
      sb_check(bus.rData1_o); sb_check(bus.rData2_o);
      sb_check(bus.dbgData_o); sb_check(bus.wrCount_o);

      // same-cycle write/read hazard on T
      wr(4'd11, 16'h00FF);
      bus.wReg_i = 1'b1; bus.wRegAddr_i = 4'd11; bus.wData_i = 16'h0001;
      bus.re1_i = 1'b1; bus.rAddr1_i = 4'd11; bus.dbgAddr_i = 4'd11;
`ifdef REGFILE_BYPASS_EN
      sb_push("hazard_r1", 16'h0001);
`else
      sb_push("hazard_r1", 16'h00FF);
`endif
      sb_push("hazard_dbg", 16'h00FF);
      #1;
      sb_check(bus.rData1_o); sb_check(bus.dbgData_o);
      @(posedge clk); #1;
      bus.wReg_i = 1'b0;
      m_regs[11] = 16'h0001; m_cnt = m_cnt + 16'd1;
      sb_push("hazard_commit", m_regs[11]);
      #1 sb_check(bus.dbgData_o);

      // invalid-address write and disabled write are dropped
      wr(4'hF, 16'h5555);
      wr(4'd2, 16'h0000);
      bus.wReg_i = 1'b0; bus.wRegAddr_i = 4'd2; bus.wData_i = 16'h7777;
      @(posedge clk); #1;
      bus.wReg_i = 1'b0; bus.wRegAddr_i = 4'hF; bus.wData_i = 16'h0000;
      @(posedge clk); #1;
      check_all_dbg("drop_regs");
      bus.rAddr1_i = 4'd13; bus.dbgAddr_i = 4'd13;
      sb_push("drop_cnt", m_cnt); sb_push("addr13_r1", 16'h0000); sb_push("addr13_dbg", 16'h0000);
      #1;
      sb_check(bus.wrCount_o); sb_check(bus.rData1_o); sb_check(bus.dbgData_o);

      // read enables
      wr(4'd5, 16'h00A5);
      bus.re1_i = 1'b0; bus.rAddr1_i = 4'd5;
      bus.re2_i = 1'b1; bus.rAddr2_i = 4'd5;
      sb_push("re1_off", 16'h0000); sb_push("re2_on", m_regs[5]);
      #1;
      sb_check(bus.rData1_o); sb_check(bus.rData2_o);
      bus.re1_i = 1'b1;

      // counter wrap
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 65535; i++) begin
         bus.wReg_i     = 1'b1;
         bus.wRegAddr_i = 4'(i % 12);
         bus.wData_i    = 16'(i) ^ 16'h3C3C;
         @(posedge clk); #1;
         m_regs[i % 12] = 16'(i) ^ 16'h3C3C;
         m_cnt          = m_cnt + 16'd1;
      end
      bus.wReg_i = 1'b0;
      sb_push("cnt_max", 16'hFFFF);
      #1 sb_check(bus.wrCount_o);
      wr(4'd7, 16'hCAFE);
      bus.dbgAddr_i = 4'd7;
      sb_push("cnt_wrap", 16'h0000); sb_push("cnt_model", m_cnt); sb_push("wrap_r7", 16'hCAFE);
      #1;
      sb_check(bus.wrCount_o); sb_check(bus.wrCount_o); sb_check(bus.dbgData_o);
      check_all_dbg("wrap_regs");

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
